ptp_stamp_capture_grp: RTL and testbench
========================================

Name: ptp_stamp_capture_grp

Overview:
Multi-port PTP event timestamp capture unit, the successor to the single-port per-MAC time_stamp logic. It watches NUM_PORTS byte streams already in the core clock domain, GMII-style. For each stream it detects the SFD and latches the free-running counter value. It then parses the Ethernet/PTP header (ethertype, messageType, sequenceId) and queues matched events into one shared FIFO, which software or the register block drains. Non-PTP frames never consume FIFO space.

Parameters:
NUM_PORTS, 4, number of monitored byte streams (1..8)
COUNTER_WIDTH, 64, width of counter_val and stored stamp
FIFO_DEPTH, 16, shared stamp FIFO entries; power of 2, minimum 2
PTP_ETHERTYPE, 16'h88F7, ethertype that qualifies a frame
DROP_CNT_WIDTH, 16, width of the saturating drop counter

Ports:
clk  in  1  core clock; all logic is on this edge
reset  in  1  synchronous, active-low reset
counter_val  in  COUNTER_WIDTH  free-running time counter
port_d  in  8*NUM_PORTS  byte stream per port; port p uses bits [8p+7:8p]
port_en  in  NUM_PORTS  byte-valid / frame-active per port
stamp_vld  out  1  FIFO head entry valid (FIFO not empty)
stamp_rd  in  1  pop head; ignored when stamp_vld=0
stamp_port  out  3  source port of head entry
stamp_msg_type  out  4  PTP messageType of head entry
stamp_seq_id  out  16  PTP sequenceId of head entry
stamp_time  out  COUNTER_WIDTH  counter_val captured at SFD
fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy
drop_cnt  out  DROP_CNT_WIDTH  events lost; saturating
drop_cnt_clr  in  1  clears drop_cnt next cycle

Behaviour:
- Reset (reset=0 at a clk edge):
  - all channel FSMs go to IDLE; pending flags clear; FIFO empties; round-robin pointer goes to 0; drop_cnt goes to 0.
  - Outputs: stamp_vld=0, fifo_count=0, stamp_* fields=0.
  - An in-flight frame is abandoned. A new frame is only recognised after port_en has been low for at least one cycle.
- Per-channel FSM states: IDLE, PRE, HDR, SKIP. Bytes are consumed only on cycles where port_en=1.
  - IDLE, port_en=1: d=0x55 -> PRE; any other byte -> SKIP.
  - PRE: d=0x55 stays in PRE. d=0xD5 -> HDR, latch counter_val (same cycle) and set idx=0. Any other byte -> SKIP.
  - HDR: idx increments each byte, where byte idx 0 is the first byte after the SFD.
    - idx 12,13: compare to PTP_ETHERTYPE (MSB first); a mismatch -> SKIP. VLAN-tagged frames therefore do not match.
    - idx 14: msg_type = d[3:0].
    - idx 44: seq_id[15:8] = d.
    - idx 45: seq_id[7:0] = d; event complete -> load holding register, pending=1, -> SKIP.
  - SKIP: wait for port_en=0.
  - port_en=0 in any state -> IDLE. A partial HDR is discarded with no event and no drop count.
- Holding register (one per channel):
  - Completion while pending=1 and the channel is not granted that cycle: the new event is discarded, drop_cnt increments (saturating at all-ones), and the old entry is kept.
  - Grant and completion on the same channel in the same cycle: the old entry is pushed, the new entry is loaded, no drop.
  - Drops from multiple channels in one cycle add their total count.
  - drop_cnt_clr together with a drop: the counter ends at the count of that cycle's drops.
- Arbiter:
  - Each cycle with FIFO not full (registered occupancy), grant exactly one pending channel.
  - Priority is round-robin, starting at last_grant+1 and wrapping at NUM_PORTS.
  - The grant pushes {port, msg_type, seq_id, stamp} and clears pending.
  - When the FIFO is full, no grant is made, even if stamp_rd pops that cycle; the grant waits for the following cycle.
- FIFO behaviour:
  - First-word fall-through; outputs present the head combinationally from registered storage.
  - Simultaneous push and pop when not full leaves fifo_count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Latency: SFD byte at cycle T gives stamp_time = counter_val@T. The last seqId byte arrives at T+46 (idx 45), pending is set at T+47, the grant is at T+47, and stamp_vld=1 from T+48 when the FIFO was empty and no contention.

Decomposition:
- Shared package ptp_stamp_pkg holds:
  - constants SFD (0xD5), PREAMBLE (0x55), IDX_ETYPE_HI=12, IDX_MSGTYPE=14, IDX_SEQ_HI=44, IDX_SEQ_LO=45;
  - FSM state encoding;
  - stamp entry field widths.
- Sub-module ptp_stamp_detect, instantiated once per port, contains the FSM, idx counter, capture registers and holding register with pending/grant/drop outputs.
- The top level holds the round-robin arbiter, FIFO and drop counter.

Test Plan:
- Port 0: 7x0x55, 0xD5 at counter_val=0x1000, ethertype 0x88F7, byte14=0x00, seq 0x1234 -> one entry {port=0, msg=0, seq=0x1234, time=0x1000}, stamp_vld rises at SFD cycle+48.
- Same frame with ethertype 0x0800 on port 1 -> no entry, fifo_count stays 0, drop_cnt=0.
- All 4 ports complete in the same cycle, last_grant=3 -> entries pop in port order 0,1,2,3 on consecutive cycles.
- FIFO filled to 16 with stamp_rd=0, then a port-2 event and a second port-2 event -> first waits pending, second drops (drop_cnt=1); after one pop the pending event enters the FIFO, count returns to 16.
- port_en drops at idx 20 -> no entry, FSM back in IDLE; the next valid frame is captured correctly.
- reset=0 asserted mid-HDR with 3 entries queued -> stamp_vld=0, fifo_count=0 the next cycle, and the frame that continues after reset deasserts produces no entry.

Source files
------------

// File: rtl/ptp_stamp_pkg.sv
// Shared definitions for the PTP event timestamp capture group.
// Holds the frame byte constants, the header byte offsets counted from the
// first byte after the SFD, the channel FSM encoding and the stamp entry
// field widths.
package ptp_stamp_pkg;

  localparam logic [7:0] SFD      = 8'hD5;
  localparam logic [7:0] PREAMBLE = 8'h55;

  // Header byte index counter: 0..45 needs 6 bits.
  localparam int IDX_W = 6;

  localparam logic [IDX_W-1:0] IDX_ETYPE_HI = 6'd12;
  localparam logic [IDX_W-1:0] IDX_ETYPE_LO = 6'd13;
  localparam logic [IDX_W-1:0] IDX_MSGTYPE  = 6'd14;
  localparam logic [IDX_W-1:0] IDX_SEQ_HI   = 6'd44;
  localparam logic [IDX_W-1:0] IDX_SEQ_LO   = 6'd45;

  // Channel FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_HDR  = 2'd2;
  localparam logic [1:0] ST_SKIP = 2'd3;

  // Stamp entry field widths (the time field width is a parameter).
  localparam int PORT_W = 3;
  localparam int MSG_W  = 4;
  localparam int SEQ_W  = 16;

  // Header part of a queued stamp entry.
  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [MSG_W-1:0]  msg_type;
    logic [SEQ_W-1:0]  seq_id;
  } stamp_hdr_t;

endpackage

// File: rtl/ptp_stamp_detect.sv
// Per-port PTP event detector.
// Watches one GMII-style byte stream, finds preamble + SFD, latches
// counter_val on the SFD byte, checks the ethertype and extracts
// messageType and sequenceId. A completed event is parked in a one-entry
// holding register until the arbiter grants it.
// Ports:
//   clk, reset        core clock, synchronous active-low reset
//   counter_val       free-running time counter
//   d, en             byte and byte-valid of this port
//   grant             arbiter takes the holding register this cycle
//   pending           holding register holds an event
//   hold_msg_type/hold_seq_id/hold_time   holding register contents
//   drop              an event completed but could not be held (pulse)
//   state_dbg         FSM state for observation
module ptp_stamp_detect
  import ptp_stamp_pkg::*;
#(
  parameter int          COUNTER_WIDTH = 64,
  parameter logic [15:0] PTP_ETHERTYPE = 16'h88F7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COUNTER_WIDTH-1:0] counter_val,
  input  logic [7:0]               d,
  input  logic                     en,
  input  logic                     grant,
  output logic                     pending,
  output logic [MSG_W-1:0]         hold_msg_type,
  output logic [SEQ_W-1:0]         hold_seq_id,
  output logic [COUNTER_WIDTH-1:0] hold_time,
  output logic                     drop,
  output logic [1:0]               state_dbg
);

  logic [1:0]               state;
  logic                     armed;
  logic [IDX_W-1:0]         idx;
  logic [COUNTER_WIDTH-1:0] cap_time;
  logic [MSG_W-1:0]         cap_msg;
  logic [7:0]               cap_seq_hi;
  logic                     complete;

  // Last sequenceId byte of a frame whose ethertype already matched.
  assign complete = en && (state == ST_HDR) && (idx == IDX_SEQ_LO);
  // The holding register stays occupied unless it is granted this cycle.
  assign drop      = complete && pending && !grant;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      armed         <= 1'b0;
      idx           <= '0;
      cap_time      <= '0;
      cap_msg       <= '0;
      cap_seq_hi    <= '0;
      pending       <= 1'b0;
      hold_msg_type <= '0;
      hold_seq_id   <= '0;
      hold_time     <= '0;
    end else begin
      // After reset the stream may be mid-frame; frames are only accepted
      // once port_en has been seen low.
      if (!en) armed <= 1'b1;

      if (!en) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= (armed && d == PREAMBLE) ? ST_PRE : ST_SKIP;
          ST_PRE: begin
            if (d == SFD) begin
              state    <= ST_HDR;
              cap_time <= counter_val;
              idx      <= '0;
            end else if (d != PREAMBLE) begin
              state <= ST_SKIP;
            end
          end
          ST_HDR: begin
            idx <= idx + 1'b1;
            if (idx == IDX_ETYPE_HI && d != PTP_ETHERTYPE[15:8]) state <= ST_SKIP;
            if (idx == IDX_ETYPE_LO && d != PTP_ETHERTYPE[7:0])  state <= ST_SKIP;
            if (idx == IDX_MSGTYPE) cap_msg    <= d[3:0];
            if (idx == IDX_SEQ_HI)  cap_seq_hi <= d;
            if (idx == IDX_SEQ_LO)  state      <= ST_SKIP;
          end
          default: state <= ST_SKIP;
        endcase
      end

      // A grant in the completion cycle frees the register for the new event.
      if (complete && (!pending || grant)) begin
        pending       <= 1'b1;
        hold_msg_type <= cap_msg;
        hold_seq_id   <= {cap_seq_hi, d};
        hold_time     <= cap_time;
      end else if (grant) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ptp_stamp_capture_grp.sv
// Multi-port PTP event timestamp capture unit.
// One ptp_stamp_detect per port feeds a round-robin arbiter that moves at
// most one held event per cycle into a shared first-word fall-through FIFO.
// Events that find their holding register occupied are counted in a
// saturating drop counter.
// Handshake: the head entry is valid while stamp_vld=1; it is consumed on
// a clk edge where stamp_vld=1 and stamp_rd=1 (stamp_rd alone is ignored).
// Ports:
//   clk, reset             core clock, synchronous active-low reset
//   counter_val            free-running time counter
//   port_d, port_en        per-port byte stream and byte-valid
//   stamp_vld, stamp_rd    FIFO head valid / pop
//   stamp_port/msg_type/seq_id/time   head entry fields (0 when empty)
//   fifo_count             FIFO occupancy
//   drop_cnt, drop_cnt_clr saturating lost-event counter and its clear
//   chan_state             per-port FSM state, 2 bits per port
module ptp_stamp_capture_grp
  import ptp_stamp_pkg::*;
#(
  parameter int          NUM_PORTS      = 4,
  parameter int          COUNTER_WIDTH  = 64,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [15:0] PTP_ETHERTYPE  = 16'h88F7,
  parameter int          DROP_CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [COUNTER_WIDTH-1:0]        counter_val,
  input  logic [8*NUM_PORTS-1:0]          port_d,
  input  logic [NUM_PORTS-1:0]            port_en,
  output logic                            stamp_vld,
  input  logic                            stamp_rd,
  output logic [PORT_W-1:0]               stamp_port,
  output logic [MSG_W-1:0]                stamp_msg_type,
  output logic [SEQ_W-1:0]                stamp_seq_id,
  output logic [COUNTER_WIDTH-1:0]        stamp_time,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [DROP_CNT_WIDTH-1:0]       drop_cnt,
  input  logic                            drop_cnt_clr,
  output logic [2*NUM_PORTS-1:0]          chan_state
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int SUM_W = $clog2(NUM_PORTS + 1);
  localparam int DW1   = DROP_CNT_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [NUM_PORTS-1:0]     pend;
  logic [NUM_PORTS-1:0]     drop;
  logic [NUM_PORTS-1:0]     grant_vec;
  logic [MSG_W-1:0]         h_msg  [NUM_PORTS];
  logic [SEQ_W-1:0]         h_seq  [NUM_PORTS];
  logic [COUNTER_WIDTH-1:0] h_time [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ch
    ptp_stamp_detect #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .PTP_ETHERTYPE (PTP_ETHERTYPE)
    ) u_det (
      .clk           (clk),
      .reset         (reset),
      .counter_val   (counter_val),
      .d             (port_d[8*g +: 8]),
      .en            (port_en[g]),
      .grant         (grant_vec[g]),
      .pending       (pend[g]),
      .hold_msg_type (h_msg[g]),
      .hold_seq_id   (h_seq[g]),
      .hold_time     (h_time[g]),
      .drop          (drop[g]),
      .state_dbg     (chan_state[2*g +: 2])
    );
  end

  // ---------------- round-robin arbiter ----------------
  logic [PORT_W-1:0] last_grant;
  logic [PORT_W-1:0] grant_idx;
  logic              grant_vld;
  logic              fifo_full;

  // Fullness uses the registered count, so a pop never opens a slot for a
  // grant in the same cycle.
  assign fifo_full = (fifo_count == FULL_CNT);

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    // Ports above last_grant first, then wrap to the ones at or below it.
    for (int c = 0; c < NUM_PORTS; c++) begin
      if (!grant_vld && pend[c] && PORT_W'(c) > last_grant) begin
        grant_vld = 1'b1;
        grant_idx = PORT_W'(c);
      end
    end
    for (int c = 0; c < NUM_PORTS; c++) begin
      if (!grant_vld && pend[c] && PORT_W'(c) <= last_grant) begin
        grant_vld = 1'b1;
        grant_idx = PORT_W'(c);
      end
    end
    if (fifo_full) grant_vld = 1'b0;
  end

  stamp_hdr_t               push_hdr;
  logic [COUNTER_WIDTH-1:0] push_time;

  always_comb begin
    grant_vec = '0;
    push_hdr  = '0;
    push_time = '0;
    for (int c = 0; c < NUM_PORTS; c++) begin
      grant_vec[c] = grant_vld && (grant_idx == PORT_W'(c));
      if (grant_vec[c]) begin
        push_hdr.port     = PORT_W'(c);
        push_hdr.msg_type = h_msg[c];
        push_hdr.seq_id   = h_seq[c];
        push_time         = h_time[c];
      end
    end
  end

  // ---------------- shared FIFO ----------------
  stamp_hdr_t               mem_hdr  [FIFO_DEPTH];
  logic [COUNTER_WIDTH-1:0] mem_time [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic                     push;
  logic                     pop;

  assign push      = grant_vld;
  assign stamp_vld = (fifo_count != '0);
  assign pop       = stamp_rd && stamp_vld;

  // Storage is not reset; the head fields are masked while empty instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_hdr[wr_ptr]  <= push_hdr;
      mem_time[wr_ptr] <= push_time;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      last_grant <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= grant_idx;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  stamp_hdr_t head_hdr;
  assign head_hdr       = stamp_vld ? mem_hdr[rd_ptr] : '0;
  assign stamp_port     = head_hdr.port;
  assign stamp_msg_type = head_hdr.msg_type;
  assign stamp_seq_id   = head_hdr.seq_id;
  assign stamp_time     = stamp_vld ? mem_time[rd_ptr] : '0;

  // ---------------- drop counter ----------------
  logic [SUM_W-1:0] drop_sum;
  logic [DW1-1:0]   drop_add;

  always_comb begin
    drop_sum = '0;
    for (int c = 0; c < NUM_PORTS; c++) drop_sum = drop_sum + SUM_W'(drop[c]);
  end

  assign drop_add = {1'b0, drop_cnt} + DW1'(drop_sum);

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (drop_cnt_clr) begin
      // Drops in the clearing cycle are still counted.
      drop_cnt <= DROP_CNT_WIDTH'(drop_sum);
    end else if (drop_add[DW1-1]) begin
      drop_cnt <= '1;
    end else begin
      drop_cnt <= drop_add[DROP_CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_ptp_stamp_capture_grp.sv
// Directed bench for ptp_stamp_capture_grp: preamble/SFD framing, ethertype
// filtering, round-robin order, FIFO-full hold and drop, abort and reset.
module tb_ptp_stamp_capture_grp;
  import ptp_stamp_pkg::*;

  localparam int NP = 4;
  localparam int CW = 64;
  localparam int FD = 16;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [CW-1:0]       counter_val;
  logic [8*NP-1:0]     port_d;
  logic [NP-1:0]       port_en;
  logic                stamp_vld;
  logic                stamp_rd;
  logic [2:0]          stamp_port;
  logic [3:0]          stamp_msg_type;
  logic [15:0]         stamp_seq_id;
  logic [CW-1:0]       stamp_time;
  logic [$clog2(FD):0] fifo_count;
  logic [DW-1:0]       drop_cnt;
  logic                drop_cnt_clr;
  logic [2*NP-1:0]     chan_state;

  ptp_stamp_capture_grp #(
    .NUM_PORTS      (NP),
    .COUNTER_WIDTH  (CW),
    .FIFO_DEPTH     (FD),
    .PTP_ETHERTYPE  (16'h88F7),
    .DROP_CNT_WIDTH (DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .counter_val    (counter_val),
    .port_d         (port_d),
    .port_en        (port_en),
    .stamp_vld      (stamp_vld),
    .stamp_rd       (stamp_rd),
    .stamp_port     (stamp_port),
    .stamp_msg_type (stamp_msg_type),
    .stamp_seq_id   (stamp_seq_id),
    .stamp_time     (stamp_time),
    .fifo_count     (fifo_count),
    .drop_cnt       (drop_cnt),
    .drop_cnt_clr   (drop_cnt_clr),
    .chan_state     (chan_state)
  );

  // ---------------- checking ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pop();
    stamp_rd = 1'b1;
    tick();
    stamp_rd = 1'b0;
  endtask

  // Byte k of a frame: 7 preamble bytes, SFD at k=7, header idx = k-8.
  function automatic logic [7:0] fbyte(input int k, input logic [15:0] etype,
                                       input logic [3:0] msg, input logic [15:0] seq);
    int h;
    h = k - 8;
    if (k < 7)  return 8'h55;
    if (k == 7) return 8'hD5;
    case (h)
      12:      return etype[15:8];
      13:      return etype[7:0];
      14:      return {4'h1, msg};
      44:      return seq[15:8];
      45:      return seq[7:0];
      default: return 8'(h * 3 + 1);
    endcase
  endfunction

  // Sends the same frame on every port in mask; port p carries seq+p.
  // counter_val equals sfd_t on the SFD byte. abort_h / rst_h are header
  // indices at which port_en drops / reset pulses (use 99 for never).
  task automatic send_frame(input logic [3:0] mask, input logic [15:0] etype,
                            input logic [3:0] msg, input logic [15:0] seq,
                            input logic [63:0] sfd_t, input int abort_h,
                            input int rst_h, input bit lat_chk);
    for (int k = 0; k < 56; k++) begin
      if (k - 8 == abort_h) break;
      counter_val = sfd_t - 64'd7 + 64'(k);
      for (int p = 0; p < NP; p++) begin
        if (mask[p]) begin
          port_en[p]       = 1'b1;
          port_d[8*p +: 8] = fbyte(k, etype, msg, seq + 16'(p));
        end
      end
      reset = (k - 8 == rst_h) ? 1'b0 : 1'b1;
      tick();
      if (k - 8 == rst_h) begin
        chk("reset_mid_vld", stamp_vld, 1'b0);
        chk("reset_mid_count", fifo_count, 5'd0);
      end
      if (lat_chk && k == 53) chk("latency_pre", stamp_vld, 1'b0);
      if (lat_chk && k == 54) chk("latency_vld", stamp_vld, 1'b1);
    end
    reset   = 1'b1;
    port_en = port_en & ~mask;
    idle(2);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset        = 1'b0;
    counter_val  = '0;
    port_d       = '0;
    port_en      = '0;
    stamp_rd     = 1'b0;
    drop_cnt_clr = 1'b0;
    idle(2);

    chk("rst_vld", stamp_vld, 1'b0);
    chk("rst_count", fifo_count, 5'd0);
    chk("rst_port", stamp_port, 3'd0);
    chk("rst_msg", stamp_msg_type, 4'd0);
    chk("rst_seq", stamp_seq_id, 16'd0);
    chk("rst_time", stamp_time, 64'd0);
    chk("rst_drop", drop_cnt, 16'd0);
    chk("rst_state", chan_state, 8'h00);

    reset = 1'b1;
    idle(2);

    // Basic capture on port 0 with latency check.
    send_frame(4'b0001, 16'h88F7, 4'h0, 16'h1234, 64'h1000, 99, 99, 1'b1);
    chk("p0_count", fifo_count, 5'd1);
    chk("p0_port", stamp_port, 3'd0);
    chk("p0_msg", stamp_msg_type, 4'h0);
    chk("p0_seq", stamp_seq_id, 16'h1234);
    chk("p0_time", stamp_time, 64'h1000);
    pop();
    chk("p0_popped", fifo_count, 5'd0);

    // Non-PTP ethertype on port 1.
    send_frame(4'b0010, 16'h0800, 4'h0, 16'h1234, 64'h1800, 99, 99, 1'b0);
    idle(2);
    chk("ipv4_count", fifo_count, 5'd0);
    chk("ipv4_vld", stamp_vld, 1'b0);
    chk("ipv4_drop", drop_cnt, 16'd0);

    // Port 3 alone so the next round starts after port 3.
    send_frame(4'b1000, 16'h88F7, 4'h1, 16'h0300, 64'h2000, 99, 99, 1'b0);
    chk("p3_port", stamp_port, 3'd3);
    chk("p3_seq", stamp_seq_id, 16'h0303);
    chk("p3_msg", stamp_msg_type, 4'h1);
    pop();

    // All four ports complete together: order 0,1,2,3.
    send_frame(4'b1111, 16'h88F7, 4'h2, 16'hA000, 64'h3000, 99, 99, 1'b0);
    idle(3);
    chk("rr_count", fifo_count, 5'd4);
    chk("rr_drop", drop_cnt, 16'd0);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("rr_port%0d", p), stamp_port, 3'(p));
      chk($sformatf("rr_seq%0d", p), stamp_seq_id, 16'hA000 + 16'(p));
      chk($sformatf("rr_time%0d", p), stamp_time, 64'h3000);
      pop();
    end
    chk("rr_empty", fifo_count, 5'd0);

    // Fill the FIFO, then one held and one dropped event on port 2.
    for (int r = 0; r < 4; r++) begin
      send_frame(4'b1111, 16'h88F7, 4'h4, 16'hB000 + 16'(4 * r), 64'h4000 + 64'(r), 99, 99, 1'b0);
      idle(3);
    end
    chk("full_count", fifo_count, 5'd16);
    send_frame(4'b0100, 16'h88F7, 4'h3, 16'h2220, 64'h5000, 99, 99, 1'b0);
    chk("held_count", fifo_count, 5'd16);
    chk("held_drop", drop_cnt, 16'd0);
    send_frame(4'b0100, 16'h88F7, 4'h3, 16'h2221, 64'h5100, 99, 99, 1'b0);
    chk("drop_cnt1", drop_cnt, 16'd1);
    chk("drop_count", fifo_count, 5'd16);
    pop();
    chk("pop_full_count", fifo_count, 5'd15);
    tick();
    chk("refill_count", fifo_count, 5'd16);
    for (int i = 0; i < 15; i++) pop();
    chk("held_port", stamp_port, 3'd2);
    chk("held_seq", stamp_seq_id, 16'h2222);
    chk("held_msg", stamp_msg_type, 4'h3);
    chk("held_time", stamp_time, 64'h5000);
    pop();
    chk("drain_count", fifo_count, 5'd0);
    drop_cnt_clr = 1'b1;
    tick();
    drop_cnt_clr = 1'b0;
    chk("drop_clr", drop_cnt, 16'd0);

    // Abort at header idx 20 on port 1, then a good frame.
    send_frame(4'b0010, 16'h88F7, 4'h5, 16'h5554, 64'h5800, 20, 99, 1'b0);
    chk("abort_count", fifo_count, 5'd0);
    chk("abort_state", chan_state[3:2], ST_IDLE);
    send_frame(4'b0010, 16'h88F7, 4'h5, 16'h5554, 64'h6000, 99, 99, 1'b0);
    chk("after_abort_port", stamp_port, 3'd1);
    chk("after_abort_seq", stamp_seq_id, 16'h5555);
    chk("after_abort_msg", stamp_msg_type, 4'h5);
    chk("after_abort_time", stamp_time, 64'h6000);
    pop();

    // Three queued entries, then reset in the middle of a port-0 header.
    send_frame(4'b0111, 16'h88F7, 4'h6, 16'h6000, 64'h7000, 99, 99, 1'b0);
    idle(2);
    chk("preq_count", fifo_count, 5'd3);
    send_frame(4'b0001, 16'h88F7, 4'h7, 16'h7000, 64'h8000, 99, 20, 1'b0);
    idle(2);
    chk("post_rst_count", fifo_count, 5'd0);
    chk("post_rst_vld", stamp_vld, 1'b0);
    chk("post_rst_drop", drop_cnt, 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
